// File: rtl/pc_redirect_unit.sv
// PC owner: sequential fetch, taken-branch redirect with flush bubbles, misaligned-target trap.
// Optional BRANCH_STATS_EN adds saturating taken / not-taken branch counters.
module pc_redirect_unit #(
  parameter logic [63:0] RESET_PC     = 64'h0000_0000_0000_0000,
  parameter logic [63:0] TRAP_VEC     = 64'h0000_0000_0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_valid,
  input  logic        take_branch,
  input  logic [63:0] branch_target,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        trap_clear,
  output logic [63:0] fetch_pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        misalign_trap,
`ifdef BRANCH_STATS_EN
  output logic [63:0] trap_addr,
  output logic [31:0] taken_cnt,
  output logic [31:0] not_taken_cnt
`else
  output logic [63:0] trap_addr
`endif
);

  typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        trap_q, trap_d;
  logic [63:0] trap_addr_q, trap_addr_d;

  logic branch_ok, taken, redirect, misalign;

  // Branch inputs are only honoured outside TRAP.
  assign branch_ok = branch_valid & (state_q != TRAP);
  assign taken     = branch_ok & take_branch;
  assign redirect  = taken & (branch_target[1:0] == 2'b00);
  assign misalign  = taken & (branch_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      cnt_q       <= 4'd0;
      flush_q     <= 1'b0;
      trap_q      <= 1'b0;
      trap_addr_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (redirect)      state_d = FLUSH;
        else if (misalign) state_d = TRAP;
      end
      FLUSH: begin
        if (redirect)          state_d = FLUSH;
        else if (misalign)     state_d = TRAP;
        else if (cnt_q == 4'd0) state_d = RUN;
      end
      TRAP: begin
        if (trap_clear) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Datapath next-state; redirect wins over the sequential increment and stall.
  always_comb begin
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    trap_d      = trap_q;
    trap_addr_d = trap_addr_q;
    if (redirect) begin
      pc_d  = branch_target;
      cnt_d = FLUSH_INIT;
    end else if (misalign) begin
      trap_d      = 1'b1;
      trap_addr_d = branch_target;
    end else begin
      unique case (state_q)
        RUN:     if (!stall && fetch_ready) pc_d = pc_q + 64'd4;
        FLUSH:   if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        TRAP: begin
          if (trap_clear) begin
            pc_d   = TRAP_VEC;
            trap_d = 1'b0;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
    flush_d = (state_d == FLUSH) | misalign;
  end

  always_comb begin
    fetch_pc      = pc_q;
    fetch_valid   = (state_q == RUN) & !stall & !rst;
    flush         = flush_q;
    misalign_trap = trap_q;
    trap_addr     = trap_addr_q;
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_q [2];
  logic [1:0]  stat_inc;

  assign stat_inc = {branch_ok & take_branch, branch_ok & !take_branch};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      always_ff @(posedge clk) begin
        if (rst)
          stat_q[gi] <= 32'd0;
        else if (stat_inc[gi] && stat_q[gi] != 32'hFFFF_FFFF)
          stat_q[gi] <= stat_q[gi] + 32'd1;
      end
    end
  endgenerate

  assign not_taken_cnt = stat_q[0];
  assign taken_cnt     = stat_q[1];
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit; stats checks compile only with BRANCH_STATS_EN.
module tb_pc_redirect_unit;
  logic        clk;
  logic        rst;
  logic        branch_valid;
  logic        take_branch;
  logic [63:0] branch_target;
  logic        fetch_ready;
  logic        stall;
  logic        trap_clear;
  logic [63:0] fetch_pc;
  logic        fetch_valid;
  logic        flush;
  logic        misalign_trap;
  logic [63:0] trap_addr;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt;
  logic [31:0] not_taken_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pc_redirect_unit dut (
    .clk           (clk),
    .rst           (rst),
    .branch_valid  (branch_valid),
    .take_branch   (take_branch),
    .branch_target (branch_target),
    .fetch_ready   (fetch_ready),
    .stall         (stall),
    .trap_clear    (trap_clear),
    .fetch_pc      (fetch_pc),
    .fetch_valid   (fetch_valid),
    .flush         (flush),
    .misalign_trap (misalign_trap),
`ifdef BRANCH_STATS_EN
    .trap_addr     (trap_addr),
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
`else
    .trap_addr     (trap_addr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic tk, input logic [63:0] tgt);
    branch_valid  = 1'b1;
    take_branch   = tk;
    branch_target = tgt;
    tick();
    branch_valid  = 1'b0;
    take_branch   = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (fetch_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", fetch_pc, 64'h0); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", fetch_valid); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %b exp 0", misalign_trap); end
    checks++; if (trap_addr !== 64'h0) begin errors++; $display("FAIL reset_trap_addr got %h exp 0", trap_addr); end
    rst = 1'b0;
    #1;
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL reset_valid_rise got %b exp 1", fetch_valid); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc;
    fetch_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 64'(4 * i);
      #1;
      checks++; if (fetch_pc !== exp_pc || fetch_valid !== 1'b1) begin
        errors++; $display("FAIL seq_pc%0d got %h/%b exp %h/1", i, fetch_pc, fetch_valid, exp_pc);
      end
      tick();
    end
    $display("test_sequential done");
  endtask

  task automatic test_redirect();
    checks++; if (fetch_pc !== 64'h10) begin errors++; $display("FAIL redir_start_pc got %h exp %h", fetch_pc, 64'h10); end
    branch(1'b1, 64'h200);
    checks++; if (flush !== 1'b1 || fetch_valid !== 1'b0 || fetch_pc !== 64'h200) begin
      errors++; $display("FAIL redir_b1 got flush=%b valid=%b pc=%h exp 1 0 200", flush, fetch_valid, fetch_pc);
    end
    tick();
    checks++; if (flush !== 1'b1 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL redir_b2 got flush=%b valid=%b exp 1 0", flush, fetch_valid);
    end
    tick();
    checks++; if (flush !== 1'b0 || fetch_valid !== 1'b1 || fetch_pc !== 64'h200) begin
      errors++; $display("FAIL redir_done got flush=%b valid=%b pc=%h exp 0 1 200", flush, fetch_valid, fetch_pc);
    end
    tick();
    checks++; if (fetch_pc !== 64'h204) begin errors++; $display("FAIL redir_next_pc got %h exp %h", fetch_pc, 64'h204); end
    $display("test_redirect done");
  endtask

  task automatic test_flush_redirect();
    branch(1'b1, 64'h280);
    branch(1'b1, 64'h300);
    checks++; if (flush !== 1'b1 || fetch_pc !== 64'h300 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL fr_reload got flush=%b pc=%h valid=%b exp 1 300 0", flush, fetch_pc, fetch_valid);
    end
    tick();
    checks++; if (flush !== 1'b1 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL fr_extend got flush=%b valid=%b exp 1 0", flush, fetch_valid);
    end
    tick();
    checks++; if (flush !== 1'b0 || fetch_valid !== 1'b1 || fetch_pc !== 64'h300) begin
      errors++; $display("FAIL fr_done got flush=%b valid=%b pc=%h exp 0 1 300", flush, fetch_valid, fetch_pc);
    end
    branch(1'b0, 64'h500);
    checks++; if (flush !== 1'b0 || fetch_pc !== 64'h304 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL not_taken got flush=%b pc=%h valid=%b exp 0 304 1", flush, fetch_pc, fetch_valid);
    end
    $display("test_flush_redirect done");
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_valid got %b exp 0", fetch_valid); end
    tick();
    checks++; if (fetch_pc !== 64'h304) begin errors++; $display("FAIL stall_hold got %h exp %h", fetch_pc, 64'h304); end
    branch(1'b1, 64'h40);
    checks++; if (fetch_pc !== 64'h40 || flush !== 1'b1) begin
      errors++; $display("FAIL stall_redir got pc=%h flush=%b exp 40 1", fetch_pc, flush);
    end
    stall = 1'b0;
    tick();
    tick();
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 64'h40 || flush !== 1'b0) begin
      errors++; $display("FAIL stall_redir_done got valid=%b pc=%h flush=%b exp 1 40 0", fetch_valid, fetch_pc, flush);
    end
    branch(1'b1, 64'h80);
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL midflush_pre got %b exp 1", flush); end
    rst = 1'b1;
    tick();
    checks++; if (fetch_pc !== 64'h0 || flush !== 1'b0 || fetch_valid !== 1'b0 || misalign_trap !== 1'b0) begin
      errors++; $display("FAIL midflush_rst got pc=%h flush=%b valid=%b trap=%b exp 0 0 0 0", fetch_pc, flush, fetch_valid, misalign_trap);
    end
    rst = 1'b0;
    #1;
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL midflush_restart got %b exp 1", fetch_valid); end
    $display("test_stall done");
  endtask

  task automatic test_misalign();
    fetch_ready = 1'b0;
    branch(1'b1, 64'h202);
    checks++; if (misalign_trap !== 1'b1 || trap_addr !== 64'h202 || flush !== 1'b1 || fetch_valid !== 1'b0 || fetch_pc !== 64'h0) begin
      errors++; $display("FAIL mis_entry got trap=%b addr=%h flush=%b valid=%b pc=%h exp 1 202 1 0 0",
                         misalign_trap, trap_addr, flush, fetch_valid, fetch_pc);
    end
    tick();
    checks++; if (flush !== 1'b0 || misalign_trap !== 1'b1 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL mis_hold got flush=%b trap=%b valid=%b exp 0 1 0", flush, misalign_trap, fetch_valid);
    end
    branch(1'b1, 64'h400);
    checks++; if (fetch_pc !== 64'h0 || misalign_trap !== 1'b1 || flush !== 1'b0) begin
      errors++; $display("FAIL mis_ignore got pc=%h trap=%b flush=%b exp 0 1 0", fetch_pc, misalign_trap, flush);
    end
    trap_clear = 1'b1;
    tick();
    trap_clear = 1'b0;
    #1;
    checks++; if (fetch_pc !== 64'h100 || misalign_trap !== 1'b0 || trap_addr !== 64'h202 || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL mis_clear got pc=%h trap=%b addr=%h valid=%b exp 100 0 202 1",
                         fetch_pc, misalign_trap, trap_addr, fetch_valid);
    end
    $display("test_misalign done");
  endtask

  task automatic test_wrap();
    fetch_ready = 1'b1;
    branch(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    tick();
    checks++; if (fetch_pc !== 64'hFFFF_FFFF_FFFF_FFFC || fetch_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_top got pc=%h valid=%b exp fffffffffffffffc 1", fetch_pc, fetch_valid);
    end
    tick();
    checks++; if (fetch_pc !== 64'h0) begin errors++; $display("FAIL wrap_zero got %h exp 0", fetch_pc); end
    $display("test_wrap done");
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (taken_cnt !== 32'd0 || not_taken_cnt !== 32'd0) begin
      errors++; $display("FAIL stats_reset got %0d/%0d exp 0/0", taken_cnt, not_taken_cnt);
    end
    branch_valid  = 1'b1;
    take_branch   = 1'b1;
    branch_target = 64'h40;
    tick();
    tick();
    tick();
    take_branch = 1'b0;
    tick();
    tick();
    branch_valid = 1'b0;
    #1;
    checks++; if (taken_cnt !== 32'd3 || not_taken_cnt !== 32'd2) begin
      errors++; $display("FAIL stats_count got %0d/%0d exp 3/2", taken_cnt, not_taken_cnt);
    end
    $display("test_stats done");
  endtask
`endif

  initial begin
    rst           = 1'b1;
    branch_valid  = 1'b0;
    take_branch   = 1'b0;
    branch_target = 64'h0;
    fetch_ready   = 1'b0;
    stall         = 1'b0;
    trap_clear    = 1'b0;
    test_reset();
    test_sequential();
    test_redirect();
    test_flush_redirect();
    test_stall();
    test_misalign();
    test_wrap();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
